button_debounce: RTL
====================

// Module: button_debounce
// PURPOSE
//  Input-side counterpart to the divided-clock LED driver: conditions one raw push-button/switch
//  input into clean, glitch-free events. Synchronises the pin, debounces on a prescaled tick,
//  and emits a level plus one-cycle press/release/long-press pulses. Runs entirely on mclk, with
//  the tick as a clock enable; no derived clocks.
// PARAMETERS
//  TICK_DIV    50000  mclk cycles per debounce tick (1 ms @ 50 MHz); legal >= 2
//  DEB_TICKS   10     consecutive stable ticks needed to accept a level change; legal >= 1
//  LONG_TICKS  1000   ticks held (after press accepted) before long_pulse; legal >= 1
//  ACTIVE_HIGH 1      1: btn_in high = pressed; 0: btn_in inverted at input
// PORTS
//  mclk          in   1  system clock
//  rs            in   1  asynchronous, active-low reset
//  btn_in        in   1  raw asynchronous button pin
//  btn_level     out  1  debounced pressed level
//  press_pulse   out  1  one-cycle strobe on accepted press
//  release_pulse out  1  one-cycle strobe on accepted release
//  long_pulse    out  1  one-cycle strobe when hold reaches LONG_TICKS
//  tick          out  1  prescaler strobe, one cycle every TICK_DIV cycles
// BEHAVIOUR
//  Reset (rs=0, async): all outputs 0, FSM=IDLE, all counters 0, sync FFs = inactive (0).
//  Input: optional inversion, then 2-FF synchroniser -> s_in (2-cycle latency).
//  Prescaler: cnt 0..TICK_DIV-1, wraps; tick=1 in the cycle cnt==TICK_DIV-1. Free-running
//   from reset, never restarted by FSM. Widths $clog2 of each max count.
//  FSM (registered outputs, pulses asserted for exactly one mclk cycle):
//   IDLE:    btn_level=0. s_in=1 -> ARM, deb_cnt<=0.
//   ARM:     s_in=0 in any cycle -> IDLE (press rejected, no pulse).
//            tick & s_in=1: deb_cnt==DEB_TICKS-1 -> PRESSED, press_pulse=1, btn_level=1,
//            long_cnt<=0, long_done<=0; else deb_cnt++.
//   PRESSED: btn_level=1. tick & !long_done: long_cnt==LONG_TICKS-1 -> long_pulse=1,
//            long_done<=1; else long_cnt++. s_in=0 -> DISARM, deb_cnt<=0.
//   DISARM:  btn_level stays 1. s_in=1 -> PRESSED (no press_pulse; long_cnt/long_done kept,
//            counting resumes). tick & s_in=0: deb_cnt==DEB_TICKS-1 -> IDLE,
//            release_pulse=1, btn_level=0; else deb_cnt++.
//  btn_level changes in the same cycle its press/release pulse is high.
//  Acceptance latency after s_in settles: (DEB_TICKS-1)*TICK_DIV+1 .. DEB_TICKS*TICK_DIV cycles.
//  long_pulse fires at most once per press; never after release_pulse; tick while
//   long_done is ignored (no counter wrap).
//  Simultaneous: s_in drop and final long tick in same cycle -> long_pulse fires, FSM -> DISARM.
//  Reset mid-operation: outputs drop to 0 immediately, no release_pulse generated; if button is
//   still held after rs=1, a fresh press is debounced and reported.
// TESTING (sim params TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=5, ACTIVE_HIGH=1)
//  1 rs=0 with btn_in=1 -> all outputs 0; rs=1, btn_in=0 for 100 cyc -> no pulses, tick every 4.
//  2 btn_in 0->1 held 60 cyc -> one press_pulse 11..15 cyc after edge, btn_level=1 same cycle;
//    long_pulse exactly once 17..20 cyc after press_pulse.
//  3 btn_in toggles every 3 cyc for 30 cyc then 0 -> no pulses, btn_level stays 0.
//  4 After test 2, btn_in->0 -> one release_pulse 11..15 cyc later, btn_level=0; no long_pulse.
//  5 Press held 16 cyc after press_pulse with 1-cycle 0 glitch at 8 -> no release,
//    long_pulse still only after 5 ticks total.
//  6 rs=0 while PRESSED, btn_in held 1 -> btn_level=0 at once, no release_pulse;
//    rs=1 -> new press_pulse 11..15 cyc later.

Source files
------------

// File: rtl/button_debounce_if.sv
// button_debounce_if: raw button pin plus the conditioned level, event strobes and tick
interface button_debounce_if;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic tick;
    modport master (
        output btn_in,
        input  btn_level, press_pulse, release_pulse, long_pulse, tick
    );
    modport slave (
        input  btn_in,
        output btn_level, press_pulse, release_pulse, long_pulse, tick
    );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: synchronise, debounce and classify one raw push-button input on mclk
module button_debounce #(
    parameter int TICK_DIV    = 50000,
    parameter int DEB_TICKS   = 10,
    parameter int LONG_TICKS  = 1000,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input logic mclk,
    input logic rs,
    button_debounce_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = DEB_TICKS > 1 ? $clog2(DEB_TICKS) : 1;
    localparam int LW = LONG_TICKS > 1 ? $clog2(LONG_TICKS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEB_TICKS - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LONG_TICKS - 1);

    typedef enum logic [1:0] {IDLE, ARM, PRESSED, DISARM} state_t;

    state_t        state;
    logic          raw;
    logic          sync1;
    logic          s_in;
    logic [PW-1:0] cnt;
    logic          tick_w;
    logic [DW-1:0] deb_cnt;
    logic [LW-1:0] long_cnt;
    logic          long_done;
    logic          level;
    logic          press;
    logic          rel;
    logic          lng;

    assign raw    = ACTIVE_HIGH ? bus.btn_in : ~bus.btn_in;
    assign tick_w = cnt == P_LAST;

    assign bus.btn_level     = level;
    assign bus.press_pulse   = press;
    assign bus.release_pulse = rel;
    assign bus.long_pulse    = lng;
    assign bus.tick          = tick_w;

    // two-flop synchroniser for the asynchronous pin, idle-low out of reset
    always_ff @(posedge mclk or negedge rs)
        if (!rs) {sync1, s_in} <= 2'b00;
        else     {sync1, s_in} <= {raw, sync1};

    // free-running prescaler; the FSM only samples its tick, never restarts it
    always_ff @(posedge mclk or negedge rs)
        if (!rs) cnt <= '0;
        else     cnt <= tick_w ? '0 : cnt + 1'b1;

    // debounce/long-press FSM with registered level and one-cycle strobes
    always_ff @(posedge mclk or negedge rs)
        if (!rs) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            long_cnt  <= '0;
            long_done <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            lng       <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            lng   <= 1'b0;
            case (state)
                IDLE: begin
                    level <= 1'b0;
                    if (s_in) begin
                        state   <= ARM;
                        deb_cnt <= '0;
                    end
                end
                ARM: begin
                    if (!s_in) state <= IDLE;
                    else if (tick_w) begin
                        if (deb_cnt == D_LAST) begin
                            state     <= PRESSED;
                            press     <= 1'b1;
                            level     <= 1'b1;
                            long_cnt  <= '0;
                            long_done <= 1'b0;
                        end else deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    level <= 1'b1;
                    if (tick_w && !long_done) begin
                        if (long_cnt == L_LAST) begin
                            lng       <= 1'b1;
                            long_done <= 1'b1;
                        end else long_cnt <= long_cnt + 1'b1;
                    end
                    if (!s_in) begin
                        state   <= DISARM;
                        deb_cnt <= '0;
                    end
                end
                DISARM: begin
                    if (s_in) state <= PRESSED;
                    else if (tick_w) begin
                        if (deb_cnt == D_LAST) begin
                            state <= IDLE;
                            rel   <= 1'b1;
                            level <= 1'b0;
                        end else deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule
